// File: rtl/ddr3_wr_pkg.sv
// Shared tag codes, FSM state encoding and default widths for the DDR3 write controller.
// Pure declarations; no logic.
package ddr3_wr_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int TAG_W_DEF     = 4;
  localparam int ADDR_W_DEF    = 23;
  localparam int BCNT_W_DEF    = 14;
  localparam int HADDR_LSB_DEF = 53;
  localparam int TOT_W_DEF     = 24;
  localparam int CREDIT_W_DEF  = 5;

  localparam int TAG_FILL = 1;
  localparam int TAG_WFM  = 2;
  localparam int TAG_CKSM = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TST_TAG,
    S_INIT_FILL,
    S_INIT_WFM,
    S_INIT_CKSM,
    S_WRITE,
    S_WRITE_CKSM,
    S_HDR_WAIT,
    S_WRITE_HDR,
    S_DONE,
    S_SYNC_ERR
  } wr_state_e;

endpackage

// File: rtl/ddr3_cbuf_addr_gen.sv
// Burst pointer with circular-region wrap and fill-start loading, plus the data-ahead-of-address credit count.
// Pointer advances one burst per accepted address; credit tracks accepted data not yet matched by an address.
module ddr3_cbuf_addr_gen
  import ddr3_wr_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_cbuf_en,
  input  logic [ADDR_W-1:0]   i_cbuf_base,
  input  logic [ADDR_W-1:0]   i_cbuf_size,
  input  logic                i_acq_enabled,
  input  logic                i_ld_fill,
  input  logic [ADDR_W-1:0]   i_ld_addr,
  input  logic                i_addr_acc,
  input  logic                i_data_acc,
  output logic [ADDR_W-1:0]   o_ptr,
  output logic [CREDIT_W-1:0] o_credit
);

  logic [ADDR_W-1:0]   r_ptr;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_acq_en_d;
  logic [ADDR_W-1:0]   w_last;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic                w_acq_rise;

  assign w_last     = i_cbuf_base + i_cbuf_size - ADDR_W'(1);
  assign w_ptr_inc  = (i_cbuf_en && (r_ptr == w_last)) ? i_cbuf_base : r_ptr + ADDR_W'(1);
  assign w_acq_rise = i_acq_enabled && !r_acq_en_d;

  // In circular mode the pointer only restarts on a new acquisition, never per fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_acq_en_d <= 1'b0;
    end else begin
      r_acq_en_d <= i_acq_enabled;
      if (i_cbuf_en && w_acq_rise)
        r_ptr <= i_cbuf_base;
      else if (i_ld_fill && !i_cbuf_en)
        r_ptr <= i_ld_addr;
      else if (i_addr_acc)
        r_ptr <= w_ptr_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_credit <= '0;
    else if (i_data_acc && !i_addr_acc)
      r_credit <= r_credit + CREDIT_W'(1);
    else if (i_addr_acc && !i_data_acc)
      r_credit <= r_credit - CREDIT_W'(1);
  end

  assign o_ptr    = r_ptr;
  assign o_credit = r_credit;

endmodule

// File: rtl/ddr3_wr_control_cbuf_p.sv
// Drains tagged ADC words from a FWFT FIFO into DDR3 address/data bursts and pushes a totalled fill header.
// Data stalls on app_wdf_rdy or full credit; the header push waits while the fill-header FIFO is full.
module ddr3_wr_control_cbuf_p
  import ddr3_wr_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BCNT_W    = BCNT_W_DEF,
  parameter int HADDR_LSB = HADDR_LSB_DEF,
  parameter int TOT_W     = TOT_W_DEF,
  parameter int CREDIT_W  = CREDIT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     acq_enabled,
  input  logic [DATA_W+TAG_W-1:0]  wr_fifo_dat,
  input  logic                     wr_fifo_empty,
  output logic                     wr_fifo_rd_en,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  input  logic                     app_wdf_rdy,
  output logic [ADDR_W+2:0]        ddr3_wr_addr,
  output logic                     wr_app_en,
  input  logic                     wr_app_rdy,
  input  logic                     cbuf_en,
  input  logic [ADDR_W-1:0]        cbuf_base,
  input  logic [ADDR_W-1:0]        cbuf_size,
  input  logic [ADDR_W-1:0]        fixed_start_addr,
  input  logic                     en_fixed_start_addr,
  output logic [DATA_W+TOT_W-1:0]  fill_header_wr_dat,
  output logic                     fill_header_wr_en,
  input  logic                     fill_header_full,
  output logic                     sync_err,
  input  logic                     sync_err_clr,
  output logic                     ddr3_wr_done,
  input  logic                     acq_done,
  output logic [15:0]              fill_count
);

  localparam int CNT_W = BCNT_W + 1;

  wr_state_e           r_state, w_next;
  logic [DATA_W-1:0]   r_hdr_payload;
  logic [CNT_W-1:0]    r_addr_cntr, r_burst_cntr;
  logic [TOT_W-1:0]    r_total, r_total_lat;
  logic                r_fill_burst;
  logic [15:0]         r_fill_count;
  logic [1:0]          r_acq_done_sync;

  logic [TAG_W-1:0]    w_tag;
  logic [DATA_W-1:0]   w_payload;
  logic                w_in_write, w_addr_acc, w_data_acc, w_cntrs_zero;
  logic [ADDR_W-1:0]   w_ptr, w_ld_addr;
  logic [CREDIT_W-1:0] w_credit;

  assign w_tag        = wr_fifo_dat[DATA_W+TAG_W-1:DATA_W];
  assign w_payload    = wr_fifo_dat[DATA_W-1:0];
  assign w_in_write   = (r_state == S_WRITE) || (r_state == S_WRITE_CKSM);
  assign w_cntrs_zero = (r_addr_cntr == '0) && (r_burst_cntr == '0);

  assign app_wdf_wren  = w_in_write && !wr_fifo_empty && (r_burst_cntr != '0) && (w_credit != '1);
  assign app_wdf_end   = app_wdf_wren;
  assign wr_app_en     = w_in_write && (w_credit != '0) && (r_addr_cntr != '0);
  assign w_data_acc    = app_wdf_wren && app_wdf_rdy;
  assign w_addr_acc    = wr_app_en && wr_app_rdy;
  assign wr_fifo_rd_en = w_data_acc;

  assign w_ld_addr    = en_fixed_start_addr ? fixed_start_addr
                                            : r_hdr_payload[HADDR_LSB +: ADDR_W];
  assign ddr3_wr_addr = {w_ptr, 3'b000};
  assign fill_header_wr_dat = {r_total_lat, r_hdr_payload};
  assign fill_count   = r_fill_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    sync_err          = 1'b0;
    ddr3_wr_done      = 1'b0;
    fill_header_wr_en = 1'b0;
    case (r_state)
      S_IDLE:       if (!wr_fifo_empty) w_next = S_TST_TAG;
      S_TST_TAG: begin
        if (w_tag == TAG_W'(TAG_FILL))      w_next = S_INIT_FILL;
        else if (w_tag == TAG_W'(TAG_WFM))  w_next = S_INIT_WFM;
        else if (w_tag == TAG_W'(TAG_CKSM)) w_next = S_INIT_CKSM;
        else                                w_next = S_SYNC_ERR;
      end
      S_INIT_FILL,
      S_INIT_WFM:   w_next = S_WRITE;
      S_INIT_CKSM:  w_next = S_WRITE_CKSM;
      S_WRITE:      if (w_cntrs_zero) w_next = S_IDLE;
      S_WRITE_CKSM: if (w_cntrs_zero) w_next = fill_header_full ? S_HDR_WAIT : S_WRITE_HDR;
      S_HDR_WAIT:   if (!fill_header_full) w_next = S_WRITE_HDR;
      S_WRITE_HDR: begin
        fill_header_wr_en = 1'b1;
        w_next            = S_DONE;
      end
      S_DONE: begin
        ddr3_wr_done = 1'b1;
        if (r_acq_done_sync[1]) w_next = S_IDLE;
      end
      S_SYNC_ERR: begin
        sync_err = 1'b1;
        if (sync_err_clr) w_next = S_IDLE;
      end
      default:      w_next = S_IDLE;
    endcase
    if (!acq_enabled) w_next = S_IDLE;
  end

  // The fill-header burst is already counted by the load of 1, so its own address accept is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_cntr  <= '0;
      r_burst_cntr <= '0;
      r_total      <= '0;
      r_fill_burst <= 1'b0;
    end else begin
      case (r_state)
        S_INIT_FILL: begin
          r_addr_cntr  <= CNT_W'(1);
          r_burst_cntr <= CNT_W'(1);
          r_total      <= TOT_W'(1);
          r_fill_burst <= 1'b1;
        end
        S_INIT_WFM: begin
          r_addr_cntr  <= CNT_W'(w_payload[BCNT_W-1:0]) + CNT_W'(1);
          r_burst_cntr <= CNT_W'(w_payload[BCNT_W-1:0]) + CNT_W'(1);
          r_fill_burst <= 1'b0;
        end
        S_INIT_CKSM: begin
          r_addr_cntr  <= CNT_W'(1);
          r_burst_cntr <= CNT_W'(1);
          r_fill_burst <= 1'b0;
        end
        default: begin
          if (w_addr_acc && (r_addr_cntr != '0))
            r_addr_cntr <= r_addr_cntr - CNT_W'(1);
          if (w_data_acc && (r_burst_cntr != '0))
            r_burst_cntr <= r_burst_cntr - CNT_W'(1);
          if (w_addr_acc && !r_fill_burst)
            r_total <= r_total + TOT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_payload   <= '0;
      r_total_lat     <= '0;
      r_fill_count    <= '0;
      r_acq_done_sync <= '0;
    end else begin
      r_acq_done_sync <= {r_acq_done_sync[0], acq_done};
      if ((r_state == S_TST_TAG) && (w_tag == TAG_W'(TAG_FILL)))
        r_hdr_payload <= w_payload;
      if ((r_state == S_WRITE_CKSM) && w_cntrs_zero)
        r_total_lat <= r_total;
      if (r_state == S_WRITE_HDR)
        r_fill_count <= r_fill_count + 16'd1;
    end
  end

  ddr3_cbuf_addr_gen #(
    .ADDR_W   (ADDR_W),
    .CREDIT_W (CREDIT_W)
  ) u_addr_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_cbuf_en     (cbuf_en),
    .i_cbuf_base   (cbuf_base),
    .i_cbuf_size   (cbuf_size),
    .i_acq_enabled (acq_enabled),
    .i_ld_fill     (r_state == S_INIT_FILL),
    .i_ld_addr     (w_ld_addr),
    .i_addr_acc    (w_addr_acc),
    .i_data_acc    (w_data_acc),
    .o_ptr         (w_ptr),
    .o_credit      (w_credit)
  );

endmodule

// File: tb/tb_ddr3_wr_control_cbuf_p.sv
// Directed bench for ddr3_wr_control_cbuf_p: FWFT FIFO model, address/data monitor and hand-computed expectations.
module tb_ddr3_wr_control_cbuf_p;

  localparam int DATA_W = 128;
  localparam int TAG_W  = 4;
  localparam int ADDR_W = 23;
  localparam int TOT_W  = 24;
  localparam int W      = DATA_W + TAG_W;
  localparam int HW     = DATA_W + TOT_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              acq_enabled;
  logic [W-1:0]      wr_fifo_dat;
  logic              wr_fifo_empty;
  logic              wr_fifo_rd_en;
  logic              app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [ADDR_W+2:0] ddr3_wr_addr;
  logic              wr_app_en, wr_app_rdy;
  logic              cbuf_en;
  logic [ADDR_W-1:0] cbuf_base, cbuf_size, fixed_start_addr;
  logic              en_fixed_start_addr;
  logic [HW-1:0]     fill_header_wr_dat;
  logic              fill_header_wr_en, fill_header_full;
  logic              sync_err, sync_err_clr, ddr3_wr_done, acq_done;
  logic [15:0]       fill_count;

  logic [W-1:0]      fifo_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  int                data_n, addr_n, hdr_n, order_viol;
  logic [HW-1:0]     last_hdr;
  int                n_checks = 0;
  int                n_fail   = 0;

  always #5 clk = ~clk;

  ddr3_wr_control_cbuf_p dut (
    .clk(clk), .reset_n(reset_n), .acq_enabled(acq_enabled),
    .wr_fifo_dat(wr_fifo_dat), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_rd_en(wr_fifo_rd_en),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .ddr3_wr_addr(ddr3_wr_addr), .wr_app_en(wr_app_en), .wr_app_rdy(wr_app_rdy),
    .cbuf_en(cbuf_en), .cbuf_base(cbuf_base), .cbuf_size(cbuf_size),
    .fixed_start_addr(fixed_start_addr), .en_fixed_start_addr(en_fixed_start_addr),
    .fill_header_wr_dat(fill_header_wr_dat), .fill_header_wr_en(fill_header_wr_en),
    .fill_header_full(fill_header_full), .sync_err(sync_err), .sync_err_clr(sync_err_clr),
    .ddr3_wr_done(ddr3_wr_done), .acq_done(acq_done), .fill_count(fill_count)
  );

  task automatic chk_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fifo_out();
    wr_fifo_empty = (fifo_q.size() == 0);
    wr_fifo_dat   = wr_fifo_empty ? '0 : fifo_q[0];
  endtask

  // Sample on the falling edge, let the rising edge commit, then update the FIFO head.
  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = wr_fifo_rd_en;
    if (wr_app_en && wr_app_rdy) begin
      if (addr_n >= data_n) order_viol++;
      addr_log.push_back(ddr3_wr_addr[ADDR_W+2:3]);
      addr_n++;
    end
    if (app_wdf_wren && app_wdf_rdy) data_n++;
    if (fill_header_wr_en) begin
      hdr_n++;
      last_hdr = fill_header_wr_dat;
    end
    @(posedge clk);
    #1;
    if (pop && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    fifo_out();
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_n = 0;
    addr_n = 0;
    hdr_n  = 0;
  endtask

  function automatic logic [DATA_W-1:0] fill_pl(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    p[53 +: ADDR_W] = a;
    p[7:0] = 8'hA5;
    return p;
  endfunction

  task automatic push_fill(input logic [ADDR_W-1:0] a, input int bcnt);
    fifo_q.push_back({4'd1, fill_pl(a)});
    fifo_q.push_back({4'd2, 128'(bcnt)});
    for (int i = 0; i < bcnt; i++) fifo_q.push_back({4'd0, 128'(i + 32'h1000)});
    fifo_q.push_back({4'd4, 128'hC0FFEE});
    fifo_out();
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!ddr3_wr_done && k < 3000) begin
      tick();
      k++;
    end
    chk_eq({tag, "_done"}, 160'(ddr3_wr_done), 160'(1));
  endtask

  task automatic release_done(input string tag);
    acq_done = 1'b1;
    repeat (4) tick();
    acq_done = 1'b0;
    tick();
    chk_eq({tag, "_done_rel"}, 160'(ddr3_wr_done), 160'(0));
  endtask

  task automatic chk_addrs(input string tag, input logic [ADDR_W-1:0] first, input int n);
    chk_eq({tag, "_naddr"}, 160'(addr_log.size()), 160'(n));
    for (int i = 0; i < n; i++)
      chk_eq({tag, "_addr"}, 160'(addr_log[i]), 160'(first + ADDR_W'(i)));
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_c [6];
    int k;
    order_viol = 0;
    reset_n = 1'b0; acq_enabled = 1'b1; app_wdf_rdy = 1'b1; wr_app_rdy = 1'b1;
    cbuf_en = 1'b0; cbuf_base = '0; cbuf_size = 23'd1; fixed_start_addr = '0;
    en_fixed_start_addr = 1'b0; fill_header_full = 1'b0; sync_err_clr = 1'b0; acq_done = 1'b0;
    clear_logs();
    fifo_out();
    repeat (3) tick();
    chk_eq("reset_outs", {wr_fifo_rd_en, app_wdf_wren, app_wdf_end, wr_app_en, fill_header_wr_en,
                          sync_err, ddr3_wr_done}, '0);
    chk_eq("reset_addr", 160'(ddr3_wr_addr), '0);
    chk_eq("reset_hdr", 160'(fill_header_wr_dat), '0);
    chk_eq("reset_fcnt", 160'(fill_count), '0);
    reset_n = 1'b1;
    tick();

    // Linear fill at header-supplied address 0x100: 1 + 4 + 1 bursts.
    clear_logs();
    push_fill(23'h100, 3);
    wait_done("t1");
    chk_addrs("t1", 23'h100, 6);
    chk_eq("t1_npush", 160'(hdr_n), 160'(1));
    chk_eq("t1_hdr", 160'(last_hdr), 160'({24'd6, fill_pl(23'h100)}));
    chk_eq("t1_fcnt", 160'(fill_count), 160'(1));
    release_done("t1");

    // Circular region 0x10..0x13, restarted by an acquisition rising edge.
    cbuf_en = 1'b1; cbuf_base = 23'h10; cbuf_size = 23'd4;
    acq_enabled = 1'b0;
    repeat (2) tick();
    acq_enabled = 1'b1;
    repeat (2) tick();
    chk_eq("t2_ptr_base", 160'(ddr3_wr_addr), 160'({23'h10, 3'b000}));
    clear_logs();
    push_fill(23'h555, 0);
    wait_done("t2a");
    release_done("t2a");
    push_fill(23'h555, 0);
    wait_done("t2b");
    exp_c = '{23'h10, 23'h11, 23'h12, 23'h13, 23'h10, 23'h11};
    chk_eq("t2_naddr", 160'(addr_log.size()), 160'(6));
    for (int i = 0; i < 6; i++) chk_eq("t2_addr", 160'(addr_log[i]), 160'(exp_c[i]));
    chk_eq("t2_tot", 160'(last_hdr[HW-1:DATA_W]), 160'(3));
    chk_eq("t2_fcnt", 160'(fill_count), 160'(3));
    release_done("t2b");

    // Address channel stalled: data runs ahead by at most 31 bursts.
    cbuf_en = 1'b0; en_fixed_start_addr = 1'b1; fixed_start_addr = 23'h300;
    clear_logs();
    push_fill(23'h7777, 40);
    k = 0;
    while (data_n < 3 && k < 500) begin
      tick();
      k++;
    end
    chk_eq("t3_start", 160'(data_n >= 3), 160'(1));
    wr_app_rdy = 1'b0;
    repeat (40) tick();
    chk_eq("t3_credit", 160'(data_n - addr_n), 160'(31));
    chk_eq("t3_wren_off", 160'(app_wdf_wren), 160'(0));
    chk_eq("t3_appen_on", 160'(wr_app_en), 160'(1));
    wr_app_rdy = 1'b1;
    wait_done("t3");
    chk_addrs("t3", 23'h300, 43);
    chk_eq("t3_tot", 160'(last_hdr[HW-1:DATA_W]), 160'(43));
    chk_eq("t3_fcnt", 160'(fill_count), 160'(4));
    release_done("t3");

    // Bad tag: sticky error until cleared, then a valid fill completes.
    en_fixed_start_addr = 1'b0;
    clear_logs();
    fifo_q.push_back({4'd7, 128'h0});
    fifo_out();
    repeat (5) tick();
    chk_eq("t4_err", 160'(sync_err), 160'(1));
    repeat (10) tick();
    chk_eq("t4_err_sticky", 160'(sync_err), 160'(1));
    chk_eq("t4_no_traffic", 160'(data_n + addr_n), 160'(0));
    fifo_q.delete();
    fifo_out();
    sync_err_clr = 1'b1;
    tick();
    sync_err_clr = 1'b0;
    tick();
    chk_eq("t4_err_clr", 160'(sync_err), 160'(0));
    push_fill(23'h40, 0);
    wait_done("t4");
    chk_addrs("t4", 23'h40, 3);
    chk_eq("t4_hdr", 160'(last_hdr), 160'({24'd3, fill_pl(23'h40)}));
    chk_eq("t4_fcnt", 160'(fill_count), 160'(5));
    release_done("t4");

    // Header FIFO full at checksum end: no push until released.
    en_fixed_start_addr = 1'b1; fixed_start_addr = 23'h500;
    fill_header_full = 1'b1;
    clear_logs();
    push_fill(23'h0, 1);
    k = 0;
    while (addr_log.size() < 4 && k < 500) begin
      tick();
      k++;
    end
    repeat (10) tick();
    chk_eq("t5_nopush", 160'(hdr_n), 160'(0));
    chk_eq("t5_notdone", 160'(ddr3_wr_done), 160'(0));
    fill_header_full = 1'b0;
    wait_done("t5");
    chk_eq("t5_npush", 160'(hdr_n), 160'(1));
    chk_eq("t5_tot", 160'(last_hdr[HW-1:DATA_W]), 160'(4));
    chk_eq("t5_fcnt", 160'(fill_count), 160'(6));
    release_done("t5");

    // Asynchronous reset in the middle of a waveform burst.
    fixed_start_addr = 23'h600;
    clear_logs();
    push_fill(23'h0, 20);
    k = 0;
    while (data_n < 5 && k < 500) begin
      tick();
      k++;
    end
    #2 reset_n = 1'b0;
    #1;
    chk_eq("t6_rst_outs", {wr_fifo_rd_en, app_wdf_wren, app_wdf_end, wr_app_en, fill_header_wr_en,
                           sync_err, ddr3_wr_done}, '0);
    chk_eq("t6_rst_addr", 160'(ddr3_wr_addr), '0);
    chk_eq("t6_rst_fcnt", 160'(fill_count), '0);
    chk_eq("t6_rst_hdr", 160'(fill_header_wr_dat), '0);
    repeat (2) tick();
    fifo_q.delete();
    fifo_out();
    reset_n = 1'b1;
    repeat (2) tick();
    fixed_start_addr = 23'h200;
    clear_logs();
    push_fill(23'h0, 0);
    wait_done("t6");
    chk_addrs("t6", 23'h200, 3);
    chk_eq("t6_npush", 160'(hdr_n), 160'(1));
    chk_eq("t6_tot", 160'(last_hdr[HW-1:DATA_W]), 160'(3));
    chk_eq("t6_fcnt", 160'(fill_count), 160'(1));
    release_done("t6");

    chk_eq("addr_after_data", 160'(order_viol), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
